// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared register-file widths and constants
package cpu_defs;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int NUM_REGS = 1 << REG_ADDR_W;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - busy vector of registers with an outstanding mul/div write
module regfile_scoreboard
    import cpu_defs::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  set_valid,
    input  logic [REG_ADDR_W-1:0] set_addr,
    input  logic                  clr_valid,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    input  logic [REG_ADDR_W-1:0] raddr1,
    input  logic [REG_ADDR_W-1:0] raddr2,
    output logic                  busy1,
    output logic                  busy2
);
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Clear first so a same-cycle re-issue of the same register stays busy; $0 is never busy
    always_comb begin
        busy_d = busy_q;
        if (clr_valid) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (set_valid && set_addr != REG_ZERO) begin
            busy_d[set_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Busy vector register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Lookups see the registered state only; the write lands at the same edge as the read
    always_comb begin
        busy1 = busy_q[raddr1];
        busy2 = busy_q[raddr2];
    end
endmodule

// File: rtl/regfile_wport_arb.sv
// rtl/regfile_wport_arb.sv - register-file write-port arbiter between pipeline WB and mul/div
module regfile_wport_arb
    import cpu_defs::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  p_valid,
    input  logic [REG_ADDR_W-1:0] p_waddr,
    input  logic [DATA_W-1:0]     p_wdata,
    output logic                  p_ready,
    input  logic                  m_valid,
    input  logic [REG_ADDR_W-1:0] m_waddr,
    input  logic [DATA_W-1:0]     m_wdata,
    output logic                  m_ready,
    input  logic                  iss_valid,
    input  logic [REG_ADDR_W-1:0] iss_waddr,
    input  logic [REG_ADDR_W-1:0] raddr1,
    input  logic [REG_ADDR_W-1:0] raddr2,
    output logic                  busy1,
    output logic                  busy2,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata
);
    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;
    logic             force_m;
    logic             grant_p;
    logic             grant_m;

    // Pipeline wins by default; mul/div takes the port once it has waited STARVE_LIMIT cycles
    always_comb begin
        force_m  = (starve_cnt_q >= CNT_W'(STARVE_LIMIT));
        grant_m  = m_valid & (~p_valid | force_m);
        grant_p  = p_valid & ~grant_m;
        p_ready  = grant_p;
        m_ready  = grant_m;
        rf_waddr = '0;
        rf_wdata = '0;
        if (grant_m) begin
            rf_waddr = m_waddr;
            rf_wdata = m_wdata;
        end else if (grant_p) begin
            rf_waddr = p_waddr;
            rf_wdata = p_wdata;
        end
        rf_we = (grant_p | grant_m) & (rf_waddr != REG_ZERO);
    end

    // Count consecutive refused mul/div cycles, saturating at the counter maximum
    always_comb begin
        starve_cnt_d = '0;
        if (m_valid && !grant_m) begin
            starve_cnt_d = (starve_cnt_q == '1) ? starve_cnt_q : starve_cnt_q + 1'b1;
        end
    end

    // Starvation counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    regfile_scoreboard u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .set_valid (iss_valid),
        .set_addr  (iss_waddr),
        .clr_valid (grant_m),
        .clr_addr  (m_waddr),
        .raddr1    (raddr1),
        .raddr2    (raddr2),
        .busy1     (busy1),
        .busy2     (busy2)
    );
endmodule
